// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry and the destination-field accessor
// used wherever a hop needs the target address of a head flit.
package noc_pkg;

    localparam int DWIDTH   = 16;
    localparam int DEST_W   = 6;
    localparam int DEST_MSB = 15;
    localparam int DEST_LSB = 10;

    function automatic logic [DEST_W-1:0] dest_of(input logic [DWIDTH-1:0] flit);
        return flit[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/spine_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read from registered storage.
// The caller guarantees push is never asserted while full without a pop.
module spine_sync_fifo #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] pop_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage is not reset: occupancy, not contents, decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);

endmodule

// File: rtl/spine_link_buffer.sv
// Elastic egress stage behind a router spine output: absorbs the valid-only
// flit stream, re-presents it as valid/ready, and reports drops and stalls.
module spine_link_buffer
    import noc_pkg::*;
#(
    parameter int DWIDTH      = noc_pkg::DWIDTH,
    parameter int DEPTH       = 8,
    parameter int DEST_W      = noc_pkg::DEST_W,
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWIDTH-1:0]        rtr_data,
    input  logic                     rtr_valid,
    output logic [DWIDTH-1:0]        link_data,
    output logic                     link_valid,
    input  logic                     link_ready,
    output logic [DEST_W-1:0]        link_dest_addr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     drop_pulse,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     stall_alarm
);

    localparam int              SW        = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0]   STALL_MAX = SW'(STALL_LIMIT);
    localparam logic [SW-1:0]   STALL_PRE = SW'(STALL_LIMIT - 1);
    localparam logic [SW-1:0]   STALL_ONE = 1;
    localparam logic [CNT_W-1:0] DROP_ONE = 1;

    logic              push;
    logic              pop;
    logic              overflow;
    logic [DWIDTH-1:0] head;
    logic [SW-1:0]     stall_cnt;

    // Handshake: a flit transfers on a rising edge where link_valid && link_ready;
    // once link_valid is high, link_data/link_dest_addr hold until that transfer.
    // The router side has no ready, so a flit arriving while full with no pop is lost.
    assign pop      = link_valid && link_ready;
    assign push     = rtr_valid && (!fifo_full || pop);
    assign overflow = rtr_valid && fifo_full && !pop;

    spine_sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data (rtr_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign link_valid     = !fifo_empty;
    assign link_data      = fifo_empty ? '0 : head;
    assign link_dest_addr = dest_of(link_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= overflow;
            if (overflow && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_ONE;
            end
        end
    end

    // Alarm sets on the same edge the counter reaches the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt   <= '0;
            stall_alarm <= 1'b0;
        end else if (pop || fifo_empty) begin
            stall_cnt   <= '0;
            stall_alarm <= 1'b0;
        end else begin
            if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + STALL_ONE;
            end
            if (stall_cnt >= STALL_PRE) begin
                stall_alarm <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spine_link_buffer.sv
// Scoreboard bench for spine_link_buffer: a reference queue predicts the
// accepted flits, drops and stall alarm cycle by cycle.
module tb_spine_link_buffer;

    localparam int DW          = 16;
    localparam int DEPTH       = 8;
    localparam int DEST_W      = 6;
    localparam int STALL_LIMIT = 64;
    localparam int CNT_W       = 2;
    localparam int DROP_MAX    = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [DW-1:0]         rtr_data;
    logic                  rtr_valid;
    logic [DW-1:0]         link_data;
    logic                  link_valid;
    logic                  link_ready;
    logic [DEST_W-1:0]     link_dest_addr;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop_pulse;
    logic [CNT_W-1:0]      drop_cnt;
    logic                  stall_alarm;

    logic [DW-1:0] exp_q[$];
    int            exp_drop_cnt;
    bit            exp_drop_pulse;
    int            exp_stall;
    bit            exp_alarm;
    int            n_vec;
    int            n_miss;

    spine_link_buffer #(
        .DWIDTH      (DW),
        .DEPTH       (DEPTH),
        .DEST_W      (DEST_W),
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rtr_data       (rtr_data),
        .rtr_valid      (rtr_valid),
        .link_data      (link_data),
        .link_valid     (link_valid),
        .link_ready     (link_ready),
        .link_dest_addr (link_dest_addr),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .drop_pulse     (drop_pulse),
        .drop_cnt       (drop_cnt),
        .stall_alarm    (stall_alarm)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_drop_cnt   = 0;
        exp_drop_pulse = 0;
        exp_stall      = 0;
        exp_alarm      = 0;
    endtask

    task automatic check_outputs();
        logic [DW-1:0] head;
        check("valid", link_valid, 32'(exp_q.size() > 0));
        check("count", fifo_count, 32'(exp_q.size()));
        check("full", fifo_full, 32'(exp_q.size() == DEPTH));
        check("empty", fifo_empty, 32'(exp_q.size() == 0));
        check("drop_pulse", drop_pulse, 32'(exp_drop_pulse));
        check("drop_cnt", drop_cnt, 32'(exp_drop_cnt));
        check("stall_alarm", stall_alarm, 32'(exp_alarm));
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            check("data", link_data, 32'(head));
            check("dest", link_dest_addr, 32'(head[15:10]));
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        rtr_valid  = 1'b0;
        link_ready = 1'b0;
        rtr_data   = '0;
        clear_model();
        check("rst_valid", link_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_data", link_data, 0);
        check("rst_dest", link_dest_addr, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_alarm", stall_alarm, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // driver: checks state left by the previous edge, then drives one cycle
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        bit nonempty, pop, push, ovf;
        @(negedge clk);
        #1;
        check_outputs();
        rtr_valid  = v;
        rtr_data   = d;
        link_ready = r;
        nonempty = exp_q.size() > 0;
        pop      = nonempty && r;
        push     = v && ((exp_q.size() < DEPTH) || pop);
        ovf      = v && !push;
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
        exp_drop_pulse = ovf;
        if (ovf && exp_drop_cnt < DROP_MAX) exp_drop_cnt++;
        if (pop || !nonempty) begin
            exp_stall = 0;
            exp_alarm = 0;
        end else begin
            if (exp_stall < STALL_LIMIT) exp_stall++;
            if (exp_stall == STALL_LIMIT) exp_alarm = 1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("drain_empty", fifo_empty, 1);
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        reset      = 1'b1;
        rtr_valid  = 1'b0;
        rtr_data   = '0;
        link_ready = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: reset mid-traffic
        for (int i = 0; i < 3; i++) step(1'b1, 16'h1230 + 16'(i), 1'b0);
        apply_reset();

        // 2: single flit, one-cycle latency
        step(1'b1, 16'hA55A, 1'b1);
        @(posedge clk); #1;
        check("t2_valid", link_valid, 1);
        check("t2_data", link_data, 16'hA55A);
        check("t2_dest", link_dest_addr, 6'h29);
        step(1'b0, '0, 1'b1);
        @(posedge clk); #1;
        check("t2_popped", link_valid, 0);

        // 3: fill and overflow
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 16'(i), 1'b0);
            if (i == 8) begin
                @(posedge clk); #1;
                check("t3_full", fifo_full, 1);
            end
        end
        step(1'b0, '0, 1'b0);
        check("t3_drop_cnt", drop_cnt, 2);
        drain();

        // 4: push and pop together while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0300 + 16'(i), 1'b1);
            @(posedge clk); #1;
            check("t4_count", fifo_count, DEPTH);
        end
        check("t4_drop_cnt", drop_cnt, 2);
        drain();

        // 5: stall watchdog
        step(1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < STALL_LIMIT - 1; i++) step(1'b0, '0, 1'b0);
        @(posedge clk); #1;
        check("t5_alarm_early", stall_alarm, 0);
        step(1'b0, '0, 1'b0);
        @(posedge clk); #1;
        check("t5_alarm", stall_alarm, 1);
        check("t5_data", link_data, 16'hBEEF);
        step(1'b0, '0, 1'b1);
        @(posedge clk); #1;
        check("t5_alarm_clear", stall_alarm, 0);

        // 6: drop counter saturation, then random traffic across pointer wrap
        apply_reset();
        for (int i = 0; i < DEPTH + 5; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        check("t6_drop_sat", drop_cnt, DROP_MAX);
        drain();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spine_link_buffer.md
Name: spine_link_buffer

Overview:
- Elastic egress stage directly downstream of one enhanced_router spine output port (spineN_out_data/valid).
- The router spine output has no backpressure. This block absorbs its valid-only flit stream into a FIFO and re-presents it to the spine link as a valid/ready stream.
- The destination address is extracted from the head flit for the next hop's spineN_dest_addr input.
- Also provides overflow-drop accounting and a stall watchdog for link debug.

Parameters:
DWIDTH, 16, flit width in bits
DEPTH, 8, FIFO entries; power of two, at least 2
DEST_W, 6, destination address width; field is flit[DWIDTH-1 -: DEST_W], i.e. [15:10]
STALL_LIMIT, 64, consecutive stalled cycles before stall_alarm asserts
CNT_W, 8, width of the drop counter

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-high reset
rtr_data  in  DWIDTH  flit from router spineN_out_data
rtr_valid  in  1  from router spineN_out_valid; no ready returned
link_data  out  DWIDTH  head flit toward spine link
link_valid  out  1  head flit valid
link_ready  in  1  downstream accepts head flit
link_dest_addr  out  DEST_W  link_data[15:10]; drives next-hop spineN_dest_addr
fifo_count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
fifo_full  out  1  fifo_count == DEPTH
fifo_empty  out  1  fifo_count == 0
drop_pulse  out  1  one-cycle pulse when an incoming flit is discarded
drop_cnt  out  CNT_W  saturating count of discarded flits
stall_alarm  out  1  head flit stalled at least STALL_LIMIT cycles

Behaviour:
- Reset (async assert, released on clk edge), all outputs at reset:
  - link_valid=0, link_data=0, link_dest_addr=0, fifo_count=0, fifo_empty=1, fifo_full=0.
  - drop_pulse=0, drop_cnt=0, stall_alarm=0.
  - Read and write pointers are cleared.
  - Reset mid-operation discards all stored flits; no partial flit survives.
- Push:
  - Push occurs on a rising edge with rtr_valid=1 when not full, or when full with a pop in the same cycle.
  - The flit is written at the write pointer; the pointer wraps modulo DEPTH.
- Pop:
  - Pop occurs when link_valid && link_ready.
  - The read pointer advances, wrapping modulo DEPTH.
- Output is first-word-fall-through from registered storage:
  - link_valid = !fifo_empty.
  - link_data = mem[rd_ptr].
  - A flit pushed into an empty FIFO at edge N is visible (link_valid=1) after edge N. Latency is 1 cycle.
- Stability: while link_valid && !link_ready, link_data and link_dest_addr hold constant (AXI-style).
- Simultaneous push and pop:
  - fifo_count is unchanged.
  - This holds when full: the flit is accepted, not dropped.
  - When empty, pop cannot occur because link_valid=0; the push lands normally.
- Overflow: rtr_valid=1, full, and no pop in that cycle:
  - The flit is discarded and storage is unchanged.
  - drop_pulse=1 in the following cycle.
  - drop_cnt increments and saturates at 2^CNT_W-1.
- Stall watchdog (counter):
  - Increments each cycle link_valid && !link_ready holds.
  - Clears to 0 on a pop or when empty.
  - stall_alarm is registered: it sets when the counter reaches STALL_LIMIT and clears on the next pop or on reset.
- Width rules:
  - fifo_count has one extra bit so it can represent DEPTH.
  - Pointers are $clog2(DEPTH) bits with natural wrap.
  - No arithmetic on flit contents.

Decomposition:
- Shared package noc_pkg:
  - DWIDTH, DEST_W, DEST_MSB=15, DEST_LSB=10.
  - Function dest_of(flit) returning the DEST_W field.
- One natural sub-module, spine_sync_fifo (parameterised DWIDTH/DEPTH):
  - Interfaces: push/pop, data, count, full, empty.
  - spine_link_buffer wraps it with drop logic, the watchdog and dest extraction.

Test Plan:
1. Reset mid-traffic:
   - Stimulus: hold link_ready=0, push 3 flits, assert reset.
   - Response: link_valid=0, fifo_count=0 and drop_cnt=0 immediately, without a clock edge.
2. Single flit:
   - Stimulus: link_ready=1, push flit 16'hA55A at edge N.
   - Response: after edge N, link_valid=1, link_data=16'hA55A and link_dest_addr=6'h29. The flit pops at edge N+1; link_valid=0 after.
3. Fill and overflow:
   - Stimulus: link_ready=0, push 10 flits 16'h0001..16'h000A.
   - Response: fifo_full after 8 pushes. Two drop_pulses; drop_cnt=2. Drain order is 0001..0008 and 0009/000A never appear.
4. Push and pop while full:
   - Stimulus: FIFO full, link_ready=1 and rtr_valid=1 together for 4 cycles.
   - Response: fifo_count stays 8, drop_cnt unchanged, output sequence is in order with no gaps.
5. Stall watchdog:
   - Stimulus: one flit, link_ready=0 for 64 cycles.
   - Response: stall_alarm=1 after 64 stalled cycles, link_data stable throughout. Raising link_ready pops the flit and clears stall_alarm on the next edge.
6. Saturation and wrap:
   - Stimulus: CNT_W=2, force 5 overflows; then 3×DEPTH push/pop cycles with random link_ready.
   - Response: drop_cnt holds at 3. Data matches a scoreboard across pointer wrap.
